// File: rtl/delay_timer_bank_if.sv
// Control/status bundle for delay_timer_bank: per-channel start/abort/delay in, busy/done status out.
// master drives requests, slave (the timer bank) drives status.
interface delay_timer_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 5
);
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] abort;
    logic [CNT_W-1:0]    delay;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
    logic                any_done;

    modport master (
        output start, abort, delay,
        input  busy, done, any_done
    );

    modport slave (
        input  start, abort, delay,
        output busy, done, any_done
    );
endinterface

// File: rtl/delay_timer_bank.sv
// Bank of retriggerable delay timers: done pulses d_eff cycles after start; outputs decode registered state only.
// No backpressure: start/abort are accepted on every edge; start beats abort, reset beats both.
module delay_timer_bank #(
    parameter int CHANNELS  = 4,
    parameter int MAX_DELAY = 16
) (
    input  logic               clk,
    input  logic               rst,
    delay_timer_bank_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_DELAY + 1);

    logic [CHANNELS-1:0] busy_q;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    d_eff;
    logic [CHANNELS-1:0] done_w;

    // Zero would never reach the cnt==1 decode, so it is promoted to one cycle.
    always_comb begin
        d_eff = bus.delay;
        if (bus.delay == '0) begin
            d_eff = CNT_W'(1);
        end else if (bus.delay > CNT_W'(MAX_DELAY)) begin
            d_eff = CNT_W'(MAX_DELAY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.start[i]) begin
                    cnt_q[i]  <= d_eff;
                    busy_q[i] <= 1'b1;
                end else if (bus.abort[i] || (busy_q[i] && cnt_q[i] == CNT_W'(1))) begin
                    cnt_q[i]  <= '0;
                    busy_q[i] <= 1'b0;
                end else if (busy_q[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        done_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            done_w[i] = busy_q[i] && (cnt_q[i] == CNT_W'(1));
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_w;
    assign bus.any_done = |done_w;
endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed vector table for delay_timer_bank, followed by randomized traffic against a deadline-based model.
module tb_delay_timer_bank;
    localparam int CH    = 4;
    localparam int MAXD  = 16;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    delay_timer_bank_if #(.CHANNELS(CH), .CNT_W(CNT_W)) bus ();

    delay_timer_bank #(.CHANNELS(CH), .MAX_DELAY(MAXD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             chk;
        logic             rst;
        logic [CH-1:0]    start;
        logic [CH-1:0]    abort;
        logic [CNT_W-1:0] delay;
        logic [CH-1:0]    busy;
        logic [CH-1:0]    done;
    } vec_t;

    vec_t vecs[$];
    int tests  = 0;
    int failed = 0;

    task automatic add(input logic c, input logic r, input logic [CH-1:0] s, input logic [CH-1:0] a,
                       input logic [CNT_W-1:0] d, input logic [CH-1:0] b, input logic [CH-1:0] dn);
        vec_t v;
        v.chk = c; v.rst = r; v.start = s; v.abort = a; v.delay = d; v.busy = b; v.done = dn;
        vecs.push_back(v);
    endtask

    // Idle row: reset released, no requests, all outputs expected low.
    task automatic idle(input int n);
        repeat (n) add(1'b1, 1'b1, 4'b0000, 4'b0000, 5'd0, 4'b0000, 4'b0000);
    endtask

    task automatic check(input string name, input int idx, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then sample outputs for that same cycle.
    task automatic drive(input logic r, input logic [CH-1:0] s, input logic [CH-1:0] a, input logic [CNT_W-1:0] d);
        @(negedge clk);
        rst       = r;
        bus.start = s;
        bus.abort = a;
        bus.delay = d;
        #1;
    endtask

    function automatic int eff(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    initial begin
        int deadline [CH];
        logic [CH-1:0] eb, ed, rs, ra;
        logic [CNT_W-1:0] rd;
        logic rr;

        bus.start = '0;
        bus.abort = '0;
        bus.delay = '0;

        // Reset held for three cycles, then released.
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 5'd0, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 5'd0, 4'b0000, 4'b0000);
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 5'd0, 4'b0000, 4'b0000);
        idle(3);

        // Basic: delay 5 on ch0.
        add(1, 1, 4'b0001, 4'b0000, 5'd5, 4'b0000, 4'b0000);
        repeat (4) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0001);
        idle(2);

        // Clamping: delay 0 on ch1 -> 1 cycle, delay 31 on ch2 -> 16 cycles.
        add(1, 1, 4'b0010, 4'b0000, 5'd0, 4'b0000, 4'b0000);
        add(1, 1, 4'b0100, 4'b0000, 5'd31, 4'b0010, 4'b0010);
        repeat (15) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0100, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0100, 4'b0100);
        idle(2);

        // Retrigger: d=8 then d=3 four cycles later; single done at +7.
        add(1, 1, 4'b0001, 4'b0000, 5'd8, 4'b0000, 4'b0000);
        repeat (3) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0001, 4'b0000, 5'd3, 4'b0001, 4'b0000);
        repeat (2) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0001);
        idle(2);

        // Retrigger in the done cycle: two pulses.
        add(1, 1, 4'b0001, 4'b0000, 5'd2, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0001, 4'b0000, 5'd3, 4'b0001, 4'b0001);
        repeat (2) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0001);
        idle(1);

        // Abort mid-count on ch3: no done afterwards.
        add(1, 1, 4'b1000, 4'b0000, 5'd6, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b1000, 4'b0000);
        add(1, 1, 4'b0000, 4'b1000, 5'd0, 4'b1000, 4'b0000);
        idle(6);

        // Abort in the done cycle keeps that pulse; abort while idle does nothing.
        add(1, 1, 4'b1000, 4'b0000, 5'd1, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b1000, 5'd0, 4'b1000, 4'b1000);
        add(1, 1, 4'b0000, 4'b1111, 5'd0, 4'b0000, 4'b0000);
        idle(1);

        // Start and abort together: start wins.
        add(1, 1, 4'b0001, 4'b0001, 5'd4, 4'b0000, 4'b0000);
        repeat (3) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0001);
        idle(1);

        // All channels together.
        add(1, 1, 4'b1111, 4'b0000, 5'd4, 4'b0000, 4'b0000);
        repeat (3) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b1111, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b1111, 4'b1111);
        idle(1);

        // Start held three cycles: done two cycles after the last one.
        add(1, 1, 4'b0001, 4'b0000, 5'd2, 4'b0000, 4'b0000);
        add(1, 1, 4'b0001, 4'b0000, 5'd2, 4'b0001, 4'b0000);
        add(1, 1, 4'b0001, 4'b0000, 5'd2, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0001);
        idle(1);

        // Reset mid-count (with a competing start) discards the pending done.
        add(1, 1, 4'b0001, 4'b0000, 5'd10, 4'b0000, 4'b0000);
        repeat (4) add(1, 1, 4'b0000, 4'b0000, 5'd0, 4'b0001, 4'b0000);
        add(1, 0, 4'b0001, 4'b0000, 5'd3, 4'b0001, 4'b0000);
        idle(8);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst, vecs[k].start, vecs[k].abort, vecs[k].delay);
            if (vecs[k].chk) begin
                check("busy", k, bus.busy, vecs[k].busy);
                check("done", k, bus.done, vecs[k].done);
                check("any_done", k, {3'b000, bus.any_done}, {3'b000, |vecs[k].done});
            end
        end

        // Random traffic; model tracks the absolute cycle each channel's done is due.
        for (int i = 0; i < CH; i++) deadline[i] = -1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rr = ($urandom_range(63) != 0);
            for (int i = 0; i < CH; i++) begin
                rs[i] = ($urandom_range(5) == 0);
                ra[i] = ($urandom_range(7) == 0);
            end
            rd = CNT_W'($urandom_range(31));
            drive(rr, rs, ra, rd);
            for (int i = 0; i < CH; i++) begin
                eb[i] = (deadline[i] >= 0) && (cyc <= deadline[i]);
                ed[i] = (cyc == deadline[i]);
            end
            check("rnd_busy", cyc, bus.busy, eb);
            check("rnd_done", cyc, bus.done, ed);
            check("rnd_any_done", cyc, {3'b000, bus.any_done}, {3'b000, |ed});
            for (int i = 0; i < CH; i++) begin
                if (!rr)        deadline[i] = -1;
                else if (rs[i]) deadline[i] = cyc + eff(int'(rd));
                else if (ra[i]) deadline[i] = -1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
